// File: rtl/pipeline_elastic.sv
// Elastic N-stage register pipeline: N-cycle latency when unblocked, one word per cycle.
// Back-pressure stalls only stages whose successor is full, so bubbles collapse while the output is blocked.
module pipeline_elastic #(
   parameter int DW = 32,
   parameter int N  = 8,
   localparam int CW = $clog2(N + 1)
) (
   input  logic          clk,
   input  logic          nreset,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic [CW-1:0] count
);

   logic [N-1:0]  r_v;
   logic [DW-1:0] r_d [N];
   logic [CW-1:0] r_count;

   logic [N-1:0]  w_go;
   logic          w_acc;
   logic [N-1:0]  w_v_in;
   logic [DW-1:0] w_d_in [N];
   logic [N-1:0]  w_v_nxt;
   logic [CW-1:0] w_cnt_nxt;

   // Accumulated from the output side so each stage's enable is computed without a vector self-loop.
   always_comb begin
      w_go  = '0;
      w_acc = out_ready;
      for (int i = N - 1; i >= 0; i--) begin
         w_acc   = w_acc | ~r_v[i];
         w_go[i] = w_acc;
      end
   end

   always_comb begin
      w_v_in    = '0;
      w_v_in[0] = in_valid;
      w_d_in[0] = in_data;
      for (int i = 1; i < N; i++) begin
         w_v_in[i] = r_v[i-1];
         w_d_in[i] = r_d[i-1];
      end
   end

   always_comb begin
      w_v_nxt   = '0;
      w_cnt_nxt = '0;
      if (!flush) begin
         for (int i = 0; i < N; i++) begin
            w_v_nxt[i] = w_go[i] ? w_v_in[i] : r_v[i];
         end
      end
      for (int i = 0; i < N; i++) begin
         w_cnt_nxt = w_cnt_nxt + CW'(w_v_nxt[i]);
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_v     <= '0;
         r_count <= '0;
         for (int i = 0; i < N; i++) begin
            r_d[i] <= '0;
         end
      end else begin
         r_v     <= w_v_nxt;
         r_count <= w_cnt_nxt;
         // Data only moves with a real word, so bubbles and flushes leave the registers quiet.
         for (int i = 0; i < N; i++) begin
            if (!flush && w_go[i] && w_v_in[i]) begin
               r_d[i] <= w_d_in[i];
            end
         end
      end
   end

   assign in_ready  = w_go[0] & ~flush;
   assign out_valid = r_v[N-1] & ~flush;
   assign out_data  = r_d[N-1];
   assign count     = r_count;

endmodule

// File: tb/tb_pipeline_elastic.sv
// Directed bench for pipeline_elastic with DW=8, N=4.
module tb_pipeline_elastic;

   logic       clk;
   logic       nreset;
   logic       flush;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [2:0] count;

   int total;
   int bad;

   pipeline_elastic #(.DW(8), .N(4)) dut (
      .clk       (clk),
      .nreset    (nreset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      nreset    = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b1;

      // reset state
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_count", count, 0);
      chk("rst_in_ready", in_ready, 1);
      tick;
      tick;
      nreset = 1'b1;
      #1;
      chk("empty_in_ready", in_ready, 1);
      chk("empty_out_valid", out_valid, 0);

      // three back-to-back words, out_ready high
      in_valid = 1'b1; in_data = 8'h11; #1;
      chk("s1_in_ready", in_ready, 1);
      tick;
      in_data = 8'h22; #1;
      chk("s1_count1", count, 1);
      chk("s1_ov_e1", out_valid, 0);
      tick;
      in_data = 8'h33; #1;
      chk("s1_count2", count, 2);
      tick;
      in_valid = 1'b0; #1;
      chk("s1_count3", count, 3);
      chk("s1_ov_e3", out_valid, 0);
      tick; #1;
      chk("s1_ov_e4", out_valid, 1);
      chk("s1_d0", out_data, 8'h11);
      chk("s1_count_e4", count, 3);
      tick; #1;
      chk("s1_ov_e5", out_valid, 1);
      chk("s1_d1", out_data, 8'h22);
      chk("s1_count_e5", count, 2);
      tick; #1;
      chk("s1_ov_e6", out_valid, 1);
      chk("s1_d2", out_data, 8'h33);
      chk("s1_count_e6", count, 1);
      tick; #1;
      chk("s1_ov_e7", out_valid, 0);
      chk("s1_count_e7", count, 0);

      // fill against a blocked output, then drain
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int k = 0; k < 6; k++) begin
         in_data = 8'hA0 + 8'((k < 4) ? k : 4);
         #1;
         chk($sformatf("s2_in_ready_%0d", k), in_ready, (k < 4) ? 1 : 0);
         tick;
      end
      #1;
      chk("s2_count_full", count, 4);
      chk("s2_ov_full", out_valid, 1);
      chk("s2_head", out_data, 8'hA0);
      out_ready = 1'b1;
      for (int j = 0; j < 6; j++) begin
         in_valid = (j < 2);
         in_data  = 8'hA4 + 8'(j);
         #1;
         chk($sformatf("s2_ov_%0d", j), out_valid, 1);
         chk($sformatf("s2_d_%0d", j), out_data, 8'hA0 + j);
         if (j < 2) chk($sformatf("s2_in_ready_drain_%0d", j), in_ready, 1);
         tick;
      end
      in_valid = 1'b0; #1;
      chk("s2_ov_end", out_valid, 0);
      chk("s2_count_end", count, 0);

      // bubble collapse behind a stalled head word
      out_ready = 1'b0;
      in_valid  = 1'b1; in_data = 8'h5A;
      tick;
      in_valid = 1'b0;
      tick; tick; tick;
      in_valid = 1'b1; in_data = 8'h6B; #1;
      chk("s3_in_ready", in_ready, 1);
      tick;
      in_valid = 1'b0;
      tick; tick; tick; #1;
      chk("s3_count", count, 2);
      chk("s3_ov", out_valid, 1);
      chk("s3_head", out_data, 8'h5A);
      out_ready = 1'b1; #1;
      chk("s3_out0", out_data, 8'h5A);
      tick; #1;
      chk("s3_ov1", out_valid, 1);
      chk("s3_out1", out_data, 8'h6B);
      tick; #1;
      chk("s3_ov_end", out_valid, 0);
      chk("s3_count_end", count, 0);

      // full pipe with simultaneous in and out
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         in_data = 8'hD0 + 8'(k);
         tick;
      end
      in_data = 8'hD4; #1;
      chk("s4_count_full", count, 4);
      chk("s4_in_ready_blk", in_ready, 0);
      tick;
      out_ready = 1'b1;
      for (int j = 0; j < 4; j++) begin
         in_data = 8'hD4 + 8'(j);
         #1;
         chk($sformatf("s4_in_ready_%0d", j), in_ready, 1);
         chk($sformatf("s4_d_%0d", j), out_data, 8'hD0 + j);
         chk($sformatf("s4_count_%0d", j), count, 4);
         tick;
      end

      // flush a full pipe with both handshakes offered
      flush = 1'b1; in_valid = 1'b1; in_data = 8'hEE; #1;
      chk("s5_in_ready", in_ready, 0);
      chk("s5_ov", out_valid, 0);
      chk("s5_count_pre", count, 4);
      tick;
      flush = 1'b0; in_valid = 1'b0; #1;
      chk("s5_count_post", count, 0);
      chk("s5_ov_post", out_valid, 0);
      chk("s5_data_kept", out_data, 8'hD4);
      tick; #1;
      chk("s5_ov_later", out_valid, 0);
      chk("s5_count_later", count, 0);

      // asynchronous reset mid-stream
      in_valid = 1'b1; in_data = 8'hE0;
      tick;
      in_data = 8'hE1;
      tick; #1;
      chk("s6_count_pre", count, 2);
      nreset = 1'b0; #1;
      chk("s6_rst_ov", out_valid, 0);
      chk("s6_rst_data", out_data, 0);
      chk("s6_rst_count", count, 0);
      chk("s6_rst_in_ready", in_ready, 1);
      in_valid = 1'b0;
      tick; tick;
      nreset = 1'b1;
      in_valid = 1'b1; in_data = 8'hC3; #1;
      chk("s6_in_ready", in_ready, 1);
      tick;
      in_valid = 1'b0; #1;
      chk("s6_ov_k", out_valid, 0);
      tick; #1;
      chk("s6_ov_k1", out_valid, 0);
      tick; #1;
      chk("s6_ov_k2", out_valid, 0);
      tick; #1;
      chk("s6_ov_k3", out_valid, 1);
      chk("s6_d_k3", out_data, 8'hC3);
      chk("s6_count_k3", count, 1);
      tick; #1;
      chk("s6_ov_end", out_valid, 0);
      chk("s6_count_end", count, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
